plot_framebuffer: RTL and testbench
===================================

# plot_framebuffer

Receiving end of the pixel-plot interface driven by the drawing engines (clear-screen filler, circle drawer, and the top-level sequencer that muxes them). It accepts one `(x, y, colour, plot)` write per cycle into a 160×120×3-bit framebuffer. On request it reads the whole frame back in raster order on a streaming output, so benches and on-chip checkers can inspect what the drawing engines produced. It also keeps saturating counts of accepted and dropped (out-of-range) plots.

## Interface
Parameters:
- `WIDTH`, default 160: frame width in pixels.
- `HEIGHT`, default 120: frame height in pixels.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `vga_x`, input, 8: plot column.
- `vga_y`, input, 7: plot row.
- `vga_colour`, input, 3: plot colour.
- `vga_plot`, input, 1: write strobe, one pixel per cycle; there is no backpressure.
- `scan_start`, input, 1: pulse to begin a raster readback.
- `scan_busy`, output, 1: a readback is in progress.
- `scan_valid`, output, 1: the `scan_x`, `scan_y` and `scan_colour` outputs hold a valid pixel this cycle.
- `scan_x`, output, 8: column of the emitted pixel.
- `scan_y`, output, 7: row of the emitted pixel.
- `scan_colour`, output, 3: stored colour of the emitted pixel.
- `scan_done`, output, 1: one-cycle pulse after the last pixel.
- `plot_count`, output, 16: accepted plots, saturating at 65535.
- `drop_count`, output, 8: rejected plots, saturating at 255.

## Operation
- **Write path:**
  - A plot is accepted when `vga_plot`=1, `vga_x`<WIDTH and `vga_y`<HEIGHT.
  - The write address is `y*WIDTH + x` (15 bits; for WIDTH=160 this is (y<<7)+(y<<5)+x). The memory is written on that edge.
  - A plot with `vga_plot`=1 and either coordinate out of range writes nothing and increments `drop_count`. No aliasing into other rows is allowed.
  - Plots to the same address on consecutive cycles: the last one wins.
- **Scanner FSM, states IDLE → READ → DRAIN → DONE → IDLE:**
  - IDLE: `scan_start`=1 moves to READ and zeroes the read address.
  - READ: issues one read address per cycle in raster order (x fastest). After issuing WIDTH*HEIGHT−1 it moves to DRAIN.
  - DRAIN: the last read datum is presented.
  - DONE: `scan_done`=1 for one cycle, then IDLE.
  - `scan_start` while not IDLE is ignored.
- **Plot during scan:**
  - Writes are never blocked.
  - A write in the same cycle as a read of the same address returns the old data (read-before-write).
  - Later reads see the new data.
- **Counters:** both saturate at their maximum and never wrap. They are cleared only by reset.
- **Reset values:**
  - `scan_busy`, `scan_valid`, `scan_done`: 0.
  - `scan_x`, `scan_y`, `scan_colour`: 0.
  - `plot_count`, `drop_count`: 0.
  - FSM: IDLE.
  - Framebuffer contents are not reset; they are undefined until written.

## Timing
- **Write:** a plot sampled at edge T is readable by a read address issued at edge T+1 or later.
- **Scan latency** (`scan_start` sampled at edge T):
  - `scan_busy`=1 from T+1.
  - First `scan_valid`, pixel (0,0), at T+2.
  - Pixel n at T+2+n; last pixel (WIDTH−1, HEIGHT−1) at T+WIDTH*HEIGHT+1.
  - `scan_done` at T+WIDTH*HEIGHT+2. `scan_busy` stays 1 through that cycle and drops at the next edge.
- **Scan output stream:** `scan_valid` is continuous, with no gaps, for exactly WIDTH*HEIGHT cycles. The `scan_x`/`scan_y` outputs are registered alongside the read data so that coordinates and colour match in every cycle.
- **Simultaneous events:** `vga_plot` and `scan_start` in the same cycle are both serviced.
- **Reset mid-scan:** on `rst_n`=0, all outputs return to their reset values asynchronously and the FSM goes to IDLE. No `scan_done` is issued for the aborted scan.

## Structure
- **Package `fb_pkg`:**
  - WIDTH/HEIGHT defaults.
  - `FB_AW` = 15.
  - `colour_t` (logic [2:0]).
  - `scan_state_t` enum {IDLE, READ, DRAIN, DONE}.
- **Sub-module `fb_ram`:**
  - Simple dual-port RAM with one write port and one read port.
  - WIDTH*HEIGHT×3 bits, registered read, read-before-write.
  - Inferable as block RAM.
- **Top module contents:** range check, address arithmetic, counters, and the scanner FSM with its coordinate pipeline registers.

## Test plan
1. **Corner pixels:** after reset, plot (0,0)=3'b010 and (159,119)=3'b111, then pulse `scan_start` at T.
   - Pixel (0,0) has colour 010 at T+2.
   - Pixel (159,119) has colour 111 at T+19201.
   - `scan_done` is high at T+19202 only.
   - `plot_count`=2.
2. **Out-of-range plots:** plot (160,10)=3'b101 and (5,120)=3'b101.
   - `drop_count`=2 and `plot_count` is unchanged.
   - A scan shows (0,11) and (5,0) still holding their previously written value, 3'b000.
3. **Last write wins:** three consecutive plots to (80,60) with colours 001, 100, 110 → a scan returns 110 at (80,60).
4. **Write during scan:** fill the frame with 000, start a scan, and write (0,0)=011 and (159,119)=011 at T+10.
   - (0,0) reads 000.
   - (159,119) reads 011.
5. **Busy and reset handling:**
   - `scan_start` pulsed while busy causes no restart; the scan completes in 19200 valid cycles.
   - Asserting `rst_n`=0 mid-scan immediately clears `scan_busy`/`scan_valid` and produces no `scan_done`.
6. **Saturation:** 300 out-of-range plots → `drop_count`=255. 70000 in-range plots → `plot_count`=65535.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the plot framebuffer slice.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 160;
  localparam int unsigned FB_HEIGHT = 120;
  localparam int unsigned FB_AW     = 15;

  typedef logic [2:0]       colour_t;
  typedef logic [FB_AW-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } scan_state_t;

  // Linear raster address y*width + x, truncated to the framebuffer address width.
  function automatic fb_addr_t fb_addr(input logic [7:0] x, input logic [6:0] y,
                                       input int unsigned width);
    return fb_addr_t'(fb_addr_t'(y) * fb_addr_t'(width)) + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/plot_framebuffer_if.sv
// Pixel-plot bus from the drawing engines: one (x, y, colour) write per cycle.
interface plot_framebuffer_if;
  import fb_pkg::*;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  colour_t    vga_colour;
  logic       vga_plot;

  modport master (output vga_x, vga_y, vga_colour, vga_plot);
  modport slave  (input  vga_x, vga_y, vga_colour, vga_plot);
endinterface

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
module fb_ram
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = FB_WIDTH * FB_HEIGHT
) (
  input  logic     clk,
  input  logic     we,
  input  fb_addr_t waddr,
  input  colour_t  wdata,
  input  logic     re,
  input  fb_addr_t raddr,
  output colour_t  rdata
);

  colour_t mem [DEPTH];

  // Write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; a same-edge write to the same address is not yet visible.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/plot_framebuffer.sv
// Framebuffer sink for the drawing engines with raster readback and plot counters.
module plot_framebuffer
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned HEIGHT = FB_HEIGHT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  plot_framebuffer_if.slave        plot,
  input  logic                     scan_start,
  output logic                     scan_busy,
  output logic                     scan_valid,
  output logic [7:0]               scan_x,
  output logic [6:0]               scan_y,
  output colour_t                  scan_colour,
  output logic                     scan_done,
  output logic [15:0]              plot_count,
  output logic [7:0]               drop_count
);

  localparam int unsigned NPIX      = WIDTH * HEIGHT;
  localparam fb_addr_t    LAST_ADDR = fb_addr_t'(NPIX - 1);
  localparam logic [7:0]  X_MAX     = 8'(WIDTH - 1);

  scan_state_t state_q, state_d;

  logic     in_range;
  logic     wr_en;
  fb_addr_t wr_addr;

  logic     rd_en;
  logic     start_ok;
  logic     busy_d;
  logic     done_d;
  fb_addr_t rd_addr;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  colour_t  rd_data;

  logic       p1_valid;
  logic [7:0] p1_x;
  logic [6:0] p1_y;

  // Range check and write address; out-of-range plots never reach the RAM.
  always_comb begin
    in_range = (32'(plot.vga_x) < WIDTH) && (32'(plot.vga_y) < HEIGHT);
    wr_en    = plot.vga_plot && in_range;
    wr_addr  = fb_addr(plot.vga_x, plot.vga_y, WIDTH);
  end

  fb_ram #(
    .DEPTH(NPIX)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (plot.vga_colour),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Saturating accepted/dropped plot counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot_count <= '0;
      drop_count <= '0;
    end else if (plot.vga_plot) begin
      if (in_range) begin
        if (plot_count != '1) plot_count <= plot_count + 16'd1;
      end else begin
        if (drop_count != '1) drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Scanner state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Scanner next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (scan_start) state_d = READ;
      READ:    if (rd_addr == LAST_ADDR) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scanner decoded controls; busy/done are registered below so they line up with the data pipeline.
  always_comb begin
    rd_en    = (state_q == READ);
    start_ok = (state_q == IDLE) && scan_start;
    busy_d   = (state_q != IDLE);
    done_d   = (state_q == DONE);
  end

  // Read address generator, raster order with x fastest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_x    <= '0;
      rd_y    <= '0;
    end else if (start_ok) begin
      rd_addr <= '0;
      rd_x    <= '0;
      rd_y    <= '0;
    end else if (rd_en) begin
      rd_addr <= rd_addr + fb_addr_t'(1);
      if (rd_x == X_MAX) begin
        rd_x <= '0;
        rd_y <= rd_y + 7'd1;
      end else begin
        rd_x <= rd_x + 8'd1;
      end
    end
  end

  // Coordinate stage matching the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_x     <= '0;
      p1_y     <= '0;
    end else begin
      p1_valid <= rd_en;
      if (rd_en) begin
        p1_x <= rd_x;
        p1_y <= rd_y;
      end
    end
  end

  // Output stage: coordinates and colour registered together; held between pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_busy   <= 1'b0;
      scan_valid  <= 1'b0;
      scan_done   <= 1'b0;
      scan_x      <= '0;
      scan_y      <= '0;
      scan_colour <= '0;
    end else begin
      scan_busy  <= busy_d;
      scan_done  <= done_d;
      scan_valid <= p1_valid;
      if (p1_valid) begin
        scan_x      <= p1_x;
        scan_y      <= p1_y;
        scan_colour <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed bench for plot_framebuffer: corners, range drops, write/scan overlap, reset, saturation.
module tb_plot_framebuffer;
  import fb_pkg::*;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_start = 1'b0;
  logic        scan_busy, scan_valid, scan_done;
  logic [7:0]  scan_x;
  logic [6:0]  scan_y;
  logic [2:0]  scan_colour;
  logic [15:0] plot_count;
  logic [7:0]  drop_count;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] exp_fb [N];
  logic [2:0] obs_fb [N];

  plot_framebuffer_if pif ();

  plot_framebuffer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .plot        (pif),
    .scan_start  (scan_start),
    .scan_busy   (scan_busy),
    .scan_valid  (scan_valid),
    .scan_x      (scan_x),
    .scan_y      (scan_y),
    .scan_colour (scan_colour),
    .scan_done   (scan_done),
    .plot_count  (plot_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_plot(input logic p, input int x, input int y, input logic [2:0] c);
    pif.vga_plot   = p;
    pif.vga_x      = 8'(x);
    pif.vga_y      = 7'(y);
    pif.vga_colour = c;
  endtask

  task automatic compare_frame(input string tag);
    int err = 0;
    for (int i = 0; i < N; i++)
      if (!$isunknown(exp_fb[i]) && obs_fb[i] !== exp_fb[i]) err++;
    check(tag, err, 0);
  endtask

  // mode 1: refill every pixel with 000 on the same edge it is read (plus (1,0)=110 on the start edge)
  // mode 2: scratch plots to (100,100)=000 every cycle, with (0,0)/(159,119)=011 at T+10/T+11
  task automatic run_scan(input int mode, input int restart_at);
    int valid_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    int first_valid = -1;
    int last_valid = -1;
    int coord_err = 0;
    for (int i = 0; i < N; i++) obs_fb[i] = 'x;
    scan_start = 1'b1;
    if (mode == 1) set_plot(1'b1, 1, 0, 3'b110);
    else           set_plot(1'b0, 0, 0, 3'b000);
    tick();
    for (int j = 1; j <= N + 4; j++) begin
      scan_start = (j == restart_at);
      if (mode == 1) begin
        if (j - 1 < N) set_plot(1'b1, (j - 1) % W, (j - 1) / W, 3'b000);
        else           set_plot(1'b0, 0, 0, 3'b000);
      end else if (j == 10) set_plot(1'b1, 0, 0, 3'b011);
      else if (j == 11)     set_plot(1'b1, W - 1, H - 1, 3'b011);
      else                  set_plot(1'b1, 100, 100, 3'b000);
      tick();
      if (j == 1) begin
        check("busy_at_T+1", scan_busy, 1);
        check("valid_at_T+1", scan_valid, 0);
      end
      if (scan_valid) begin
        if (first_valid < 0) first_valid = j;
        last_valid = j;
        if (valid_cnt < N) begin
          if (scan_x != 8'(valid_cnt % W) || scan_y != 7'(valid_cnt / W)) coord_err++;
          obs_fb[valid_cnt] = scan_colour;
        end
        valid_cnt++;
      end
      if (scan_done) begin
        done_cnt++;
        done_at = j;
      end
      if (j == N + 2) check("busy_in_done_cycle", scan_busy, 1);
      if (j == N + 3) check("busy_after_done", scan_busy, 0);
    end
    scan_start = 1'b0;
    set_plot(1'b0, 0, 0, 3'b000);
    check("first_valid_offset", first_valid, 2);
    check("last_valid_offset", last_valid, N + 1);
    check("valid_cycles", valid_cnt, N);
    check("done_pulses", done_cnt, 1);
    check("done_offset", done_at, N + 2);
    check("raster_coords_errors", coord_err, 0);
  endtask

  initial begin
    int dv;
    int bv;
    set_plot(1'b0, 0, 0, 3'b000);

    // Reset state
    repeat (3) tick();
    check("rst_busy", scan_busy, 0);
    check("rst_valid", scan_valid, 0);
    check("rst_done", scan_done, 0);
    check("rst_x", scan_x, 0);
    check("rst_y", scan_y, 0);
    check("rst_colour", scan_colour, 0);
    check("rst_plot_count", plot_count, 0);
    check("rst_drop_count", drop_count, 0);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_busy", scan_busy, 0);

    // Corner plots
    set_plot(1'b1, 0, 0, 3'b010);       tick();
    set_plot(1'b1, W - 1, H - 1, 3'b111); tick();
    set_plot(1'b0, 0, 0, 3'b000);
    check("plot_count_corners", plot_count, 2);
    check("drop_count_corners", drop_count, 0);

    // Out-of-range plots
    set_plot(1'b1, 160, 10, 3'b101); tick();
    set_plot(1'b1, 5, 120, 3'b101);  tick();
    set_plot(1'b0, 0, 0, 3'b000);
    check("drop_count_oor", drop_count, 2);
    check("plot_count_oor", plot_count, 2);

    // Scan 1: corners, simultaneous plot+start, read-before-write refill, ignored restart
    for (int i = 0; i < N; i++) exp_fb[i] = 'x;
    exp_fb[0]     = 3'b010;
    exp_fb[1]     = 3'b110;
    exp_fb[N - 1] = 3'b111;
    run_scan(1, 100);
    check("scan1_px_0_0", obs_fb[0], 3'b010);
    check("scan1_px_1_0", obs_fb[1], 3'b110);
    check("scan1_px_159_119", obs_fb[N - 1], 3'b111);
    compare_frame("scan1_frame");
    check("plot_count_scan1", plot_count, 19203);
    check("drop_count_scan1", drop_count, 2);

    // Last write wins, plus an in-range cycle with vga_plot low
    set_plot(1'b1, 80, 60, 3'b001); tick();
    set_plot(1'b1, 80, 60, 3'b100); tick();
    set_plot(1'b1, 80, 60, 3'b110); tick();
    set_plot(1'b0, 5, 0, 3'b111);   tick();
    set_plot(1'b0, 0, 0, 3'b000);
    check("plot_count_lww", plot_count, 19206);

    // Scan 2: write during scan, start ignored in DONE
    for (int i = 0; i < N; i++) exp_fb[i] = 3'b000;
    exp_fb[60 * W + 80] = 3'b110;
    exp_fb[N - 1]       = 3'b011;
    run_scan(2, N + 2);
    check("scan2_px_0_0_old", obs_fb[0], 3'b000);
    check("scan2_px_159_119_new", obs_fb[N - 1], 3'b011);
    check("scan2_px_0_11", obs_fb[11 * W], 3'b000);
    check("scan2_px_5_0", obs_fb[5], 3'b000);
    check("scan2_px_80_60", obs_fb[60 * W + 80], 3'b110);
    compare_frame("scan2_frame");
    check("plot_count_scan2", plot_count, 38410);

    // Drop saturation
    for (int i = 0; i < 252; i++) begin
      if (i % 2 == 0) set_plot(1'b1, 160 + (i % 96), 5, 3'b001);
      else            set_plot(1'b1, 3, 120 + (i % 8), 3'b001);
      tick();
    end
    set_plot(1'b0, 0, 0, 3'b000);
    check("drop_count_254", drop_count, 254);
    check("plot_count_during_drops", plot_count, 38410);
    set_plot(1'b1, 255, 127, 3'b001); tick();
    set_plot(1'b0, 0, 0, 3'b000);
    check("drop_count_255", drop_count, 255);
    set_plot(1'b1, 200, 0, 3'b001);
    repeat (46) tick();
    set_plot(1'b0, 0, 0, 3'b000);
    check("drop_count_sat", drop_count, 255);

    // Plot saturation
    set_plot(1'b1, 100, 100, 3'b000);
    repeat (27124) tick();
    set_plot(1'b0, 0, 0, 3'b000);
    check("plot_count_65534", plot_count, 65534);
    set_plot(1'b1, 100, 100, 3'b000); tick();
    set_plot(1'b0, 0, 0, 3'b000);
    check("plot_count_65535", plot_count, 65535);
    set_plot(1'b1, 100, 100, 3'b000);
    repeat (3000) tick();
    set_plot(1'b0, 0, 0, 3'b000);
    check("plot_count_sat", plot_count, 65535);

    // Reset mid-scan
    scan_start = 1'b1; tick();
    scan_start = 1'b0;
    repeat (50) tick();
    check("midscan_valid", scan_valid, 1);
    check("midscan_busy", scan_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", scan_busy, 0);
    check("arst_valid", scan_valid, 0);
    check("arst_done", scan_done, 0);
    check("arst_x", scan_x, 0);
    check("arst_y", scan_y, 0);
    check("arst_colour", scan_colour, 0);
    check("arst_plot_count", plot_count, 0);
    check("arst_drop_count", drop_count, 0);
    tick();
    #3 rst_n = 1'b1;
    dv = 0;
    bv = 0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (scan_done) dv++;
      if (scan_busy || scan_valid) bv++;
    end
    check("aborted_scan_done", dv, 0);
    check("aborted_scan_activity", bv, 0);

    // Fresh scan after reset starts cleanly from IDLE
    scan_start = 1'b1; tick();
    scan_start = 1'b0;
    tick();
    check("rescan_busy_T+1", scan_busy, 1);
    check("rescan_valid_T+1", scan_valid, 0);
    tick();
    check("rescan_valid_T+2", scan_valid, 1);
    check("rescan_x", scan_x, 0);
    check("rescan_y", scan_y, 0);
    check("rescan_colour", scan_colour, 3'b011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
